// File: rtl/fir_sched_pkg.sv
// Shared types and constants for the FIR channel scheduler: FSM state encoding and
// the channel-index width helper.
package fir_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StWaitDone,
    StEmit
  } sched_state_e;

  function automatic int unsigned ch_idx_w(int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  localparam int unsigned CH_IDX_W = ch_idx_w(4);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester found searching upward from
// (last_i + 1) mod NumReq.
module rr_arbiter #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdxW   = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdxW-1:0]   last_i,
  output logic [IdxW-1:0]   gnt_idx_o,
  output logic              gnt_valid_o
);

  always_comb begin
    int unsigned idx;
    idx         = 0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned i = 1; i <= NumReq; i++) begin
      idx = (32'(last_i) + i) % NumReq;
      if (!gnt_valid_o && req_i[IdxW'(idx)]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Multiplexes NUM_CH audio channels onto one shared serial-MAC FIR engine.
// Define FIR_SCHED_STATS_EN to add the per-channel grant_cnt output.
module fir_channel_scheduler
  import fir_sched_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [NUM_CH*WIDTH-1:0]   audio_in,
  input  logic [NUM_CH-1:0]         valid_in,
  output logic                      eng_start,
  output logic [$clog2(NUM_CH)-1:0] eng_ch,
  output logic signed [WIDTH-1:0]   eng_sample,
  input  logic                      eng_done,
  input  logic [WIDTH-1:0]          eng_result,
  output logic [WIDTH-1:0]          filtered_audio,
  output logic [$clog2(NUM_CH)-1:0] ch_out,
  output logic                      data_ready,
  output logic [NUM_CH-1:0]         overrun,
`ifdef FIR_SCHED_STATS_EN
  output logic [NUM_CH*16-1:0]      grant_cnt,
`endif
  output logic                      timeout_err
);

  localparam int unsigned ChIdxW = ch_idx_w(NUM_CH);
  localparam int unsigned TmrW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  sched_state_e                  state_q, state_d;
  logic [NUM_CH-1:0]             pend_q, pend_d;
  logic [NUM_CH-1:0][WIDTH-1:0]  samp_q, samp_d;
  logic [ChIdxW-1:0]             sel_q, sel_d;
  logic [ChIdxW-1:0]             last_q, last_d;
  logic [TmrW-1:0]               tmr_q, tmr_d;
  logic [WIDTH-1:0]              result_q, result_d;
  logic [ChIdxW-1:0]             ch_q, ch_d;
  logic [NUM_CH-1:0]             ovr_q, ovr_d;
  logic                          tmo_q, tmo_d;
  logic [NUM_CH-1:0]             clr_mask;
  logic [ChIdxW-1:0]             arb_idx;
  logic                          arb_valid;

  rr_arbiter #(
    .NumReq (NUM_CH),
    .IdxW   (ChIdxW)
  ) u_rr_arbiter (
    .req_i       (pend_q),
    .last_i      (last_q),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    samp_d   = samp_q;
    sel_d    = sel_q;
    last_d   = last_q;
    tmr_d    = tmr_q;
    result_d = result_q;
    ch_d     = ch_q;
    ovr_d    = ovr_q;
    tmo_d    = tmo_q;
    clr_mask = '0;

    if (state_q == StGrant) begin
      clr_mask[sel_q] = 1'b1;
    end

    // A new sample on the channel being granted this cycle re-arms it without overrun.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (valid_in[k]) begin
        samp_d[k] = audio_in[k*WIDTH +: WIDTH];
        if (pend_q[k] && !clr_mask[k]) begin
          ovr_d[k] = 1'b1;
        end
      end
    end
    pend_d = (pend_q & ~clr_mask) | valid_in;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          sel_d   = arb_idx;
          last_d  = arb_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        tmr_d   = '0;
        state_d = StWaitDone;
      end
      StWaitDone: begin
        if (eng_done) begin
          result_d = eng_result;
          ch_d     = sel_q;
          state_d  = StEmit;
        end else if (tmr_q == TmrW'(TIMEOUT - 1)) begin
          tmo_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StEmit: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= StIdle;
      pend_q   <= '0;
      samp_q   <= '0;
      sel_q    <= '0;
      last_q   <= ChIdxW'(NUM_CH - 1);
      tmr_q    <= '0;
      result_q <= '0;
      ch_q     <= '0;
      ovr_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      samp_q   <= samp_d;
      sel_q    <= sel_d;
      last_q   <= last_d;
      tmr_q    <= tmr_d;
      result_q <= result_d;
      ch_q     <= ch_d;
      ovr_q    <= ovr_d;
      tmo_q    <= tmo_d;
    end
  end

  assign eng_start      = (state_q == StGrant);
  assign eng_ch         = sel_q;
  assign eng_sample     = samp_q[sel_q];
  assign filtered_audio = result_q;
  assign ch_out         = ch_q;
  assign data_ready     = (state_q == StEmit);
  assign overrun        = ovr_q;
  assign timeout_err    = tmo_q;

`ifdef FIR_SCHED_STATS_EN
  logic [NUM_CH-1:0][15:0] gcnt_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      gcnt_q <= '0;
    end else if (state_q == StGrant) begin
      gcnt_q[sel_q] <= gcnt_q[sel_q] + 16'd1;
    end
  end

  assign grant_cnt = gcnt_q;
`endif

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Bench for fir_channel_scheduler: directed scenarios plus random traffic, checked
// against a transaction-level model of pending samples, round-robin grants and engine.
module tb_fir_channel_scheduler;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst_in;
  logic [N*W-1:0] audio_in;
  logic [N-1:0]   valid_in;
  logic           eng_start;
  logic [1:0]     eng_ch;
  logic [W-1:0]   eng_sample;
  logic           eng_done;
  logic [W-1:0]   eng_result;
  logic [W-1:0]   filtered_audio;
  logic [1:0]     ch_out;
  logic           data_ready;
  logic [N-1:0]   overrun;
  logic           timeout_err;
`ifdef FIR_SCHED_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  fir_channel_scheduler #(
    .WIDTH   (W),
    .NUM_CH  (N),
    .TIMEOUT (TMO)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .audio_in       (audio_in),
    .valid_in       (valid_in),
    .eng_start      (eng_start),
    .eng_ch         (eng_ch),
    .eng_sample     (eng_sample),
    .eng_done       (eng_done),
    .eng_result     (eng_result),
    .filtered_audio (filtered_audio),
    .ch_out         (ch_out),
    .data_ready     (data_ready),
    .overrun        (overrun),
`ifdef FIR_SCHED_STATS_EN
    .grant_cnt      (grant_cnt),
`endif
    .timeout_err    (timeout_err)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state
  logic [N-1:0] m_pend, snap_prev, m_ovr;
  logic [W-1:0] m_samp [N];
  logic [1:0]   m_last, m_ch, g_ch;
  logic         m_tmo;
  logic [W-1:0] m_fa, g_res, last_samp;
  bit           busy, hold, free_prev, dr_next, rst_prev;
  int           due, grant_cyc, dr_count;
  int           ghist[$];

  // Stimulus controls
  logic [N-1:0] drv_valid;
  logic [W-1:0] drv_audio [N];
  bit           drv_rst, drv_done, hold_once, mode_res_en;
  logic [W-1:0] drv_res, mode_res;
  int           mode_lat, hold_rate, rearm_ch;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [1:0] rr_pick(input logic [N-1:0] req, input logic [1:0] last);
    logic [1:0] idx;
    for (int i = 1; i <= N; i++) begin
      idx = last + 2'(i);
      if (req[idx]) return idx;
    end
    return 2'd0;
  endfunction

  task automatic model_reset();
    m_pend    = '0;
    snap_prev = '0;
    m_last    = 2'(N - 1);
    m_ovr     = '0;
    m_tmo     = 1'b0;
    m_fa      = '0;
    m_ch      = '0;
    busy      = 0;
    free_prev = 0;
    dr_next   = 0;
  endtask

  // One clock: observe/check outputs of this cycle, then drive inputs for it.
  task automatic tick();
    logic         exp_dr, exp_start, free_c;
    logic [N-1:0] cur;
    logic [1:0]   ch;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_prev) model_reset();
    exp_dr  = dr_next;
    dr_next = 0;
    if (exp_dr) begin
      m_fa = g_res;
      m_ch = g_ch;
      dr_count++;
    end
    if (busy && hold && cyc == due) begin
      m_tmo = 1'b1;
      busy  = 0;
    end
    exp_start = free_prev && (snap_prev != '0);
    check("eng_start", eng_start, exp_start);
    check("data_ready", data_ready, exp_dr);
    check("filtered_audio", filtered_audio, m_fa);
    check("ch_out", ch_out, m_ch);
    check("overrun", overrun, m_ovr);
    check("timeout_err", timeout_err, m_tmo);
    cur = m_pend;
    if (exp_start) begin
      ch = rr_pick(snap_prev, m_last);
      check("eng_ch", eng_ch, ch);
      check("eng_sample", eng_sample, m_samp[ch]);
      ghist.push_back(int'(eng_ch));
      last_samp  = eng_sample;
      m_pend[ch] = 1'b0;
      m_last     = ch;
      busy       = 1;
      g_ch       = ch;
      grant_cyc  = cyc;
      hold       = hold_once || (hold_rate != 0 && $urandom_range(hold_rate - 1) == 0);
      hold_once  = 0;
      due        = hold ? cyc + TMO + 1 : cyc + ((mode_lat != 0) ? mode_lat : $urandom_range(1, 6));
      g_res      = mode_res_en ? mode_res : W'($urandom);
      if (rearm_ch >= 0 && int'(ch) == rearm_ch) begin
        drv_valid[ch] = 1'b1;
        drv_audio[ch] = W'($urandom);
        rearm_ch      = -1;
      end
    end
    free_c    = !busy && !exp_dr && !exp_start;
    snap_prev = cur;
    free_prev = free_c;

    rst_in   = drv_rst;
    rst_prev = drv_rst;
    drv_rst  = 0;
    valid_in = drv_valid;
    for (int k = 0; k < N; k++) begin
      audio_in[k*W +: W] = drv_audio[k];
      if (drv_valid[k]) begin
        if (m_pend[k]) m_ovr[k] = 1'b1;
        m_samp[k] = drv_audio[k];
        m_pend[k] = 1'b1;
      end
    end
    drv_valid  = '0;
    eng_done   = 1'b0;
    eng_result = W'($urandom);
    if (busy && !hold && cyc == due) begin
      eng_done   = 1'b1;
      eng_result = g_res;
      dr_next    = 1;
      busy       = 0;
    end else if (drv_done && !busy) begin
      eng_done   = 1'b1;
      eng_result = drv_res;
    end
    drv_done = 0;
  endtask

  task automatic do_reset();
    drv_rst = 1;
    tick();
    tick();
    ghist.delete();
    dr_count = 0;
  endtask

  initial begin
    int t0;
    rst_in      = 1'b1;
    valid_in    = '0;
    audio_in    = '0;
    eng_done    = 1'b0;
    eng_result  = '0;
    rst_prev    = 1;
    drv_valid   = '0;
    drv_rst     = 0;
    drv_done    = 0;
    drv_res     = '0;
    hold_once   = 0;
    hold_rate   = 0;
    mode_lat    = 0;
    mode_res_en = 0;
    mode_res    = '0;
    rearm_ch    = -1;
    dr_count    = 0;
    last_samp   = '0;
    grant_cyc   = 0;
    for (int k = 0; k < N; k++) drv_audio[k] = '0;
    model_reset();

    // Reset state and single-channel path
    do_reset();
    check("reset_overrun", overrun, 4'b0000);
    check("reset_eng_start", eng_start, 1'b0);
    mode_lat     = 1;
    mode_res_en  = 1;
    mode_res     = 8'h2A;
    drv_valid    = 4'b0001;
    drv_audio[0] = 8'd5;
    tick();
    t0 = cyc;
    repeat (6) tick();
    check("single_latency", grant_cyc - t0, 2);
    check("single_sample", last_samp, 8'd5);
    check("single_fa", filtered_audio, 8'h2A);
    check("single_ch", ch_out, 2'd0);
    check("single_dr_cnt", dr_count, 1);

    // Four-way contention from reset
    do_reset();
    mode_lat    = 0;
    mode_res_en = 0;
    drv_valid   = 4'b1111;
    for (int k = 0; k < N; k++) drv_audio[k] = W'($urandom);
    tick();
    repeat (50) tick();
    for (int i = 0; i < 4; i++) check("contention_order", (i < ghist.size()) ? ghist[i] : -1, i);
    check("contention_dr_cnt", dr_count, 4);
    check("contention_overrun", overrun, 4'b0000);

    // Overrun: two samples on channel 2 before its grant
    do_reset();
    drv_valid    = 4'b0100;
    drv_audio[2] = 8'd3;
    tick();
    drv_valid    = 4'b0100;
    drv_audio[2] = 8'd7;
    tick();
    repeat (12) tick();
    check("overrun_sample", last_samp, 8'd7);
    check("overrun_flags", overrun, 4'b0100);
    check("overrun_grant", (ghist.size() > 0) ? ghist[0] : -1, 2);

    // Engine timeout on channel 0, then channel 1 served
    do_reset();
    hold_once = 1;
    drv_valid = 4'b0011;
    for (int k = 0; k < N; k++) drv_audio[k] = W'($urandom);
    tick();
    repeat (TMO + 20) tick();
    check("timeout_flag", timeout_err, 1'b1);
    check("timeout_grants", ghist.size(), 2);
    check("timeout_next_ch", (ghist.size() > 1) ? ghist[1] : -1, 1);
    check("timeout_dr_cnt", dr_count, 1);
    check("timeout_ch_out", ch_out, 2'd1);

    // Reset while waiting; a late eng_done must be ignored
    do_reset();
    hold_once = 1;
    drv_valid = 4'b0001;
    tick();
    repeat (5) tick();
    drv_rst = 1;
    tick();
    tick();
    drv_done = 1;
    drv_res  = 8'h55;
    tick();
    repeat (3) tick();
    check("rstwait_dr_cnt", dr_count, 0);
    check("rstwait_fa", filtered_audio, 8'h00);
    check("rstwait_tmo", timeout_err, 1'b0);
    check("rstwait_start", eng_start, 1'b0);

    // New sample on channel 1 during its own grant: re-granted after 2, no overrun
    do_reset();
    mode_lat  = 3;
    drv_valid = 4'b0111;
    for (int k = 0; k < N; k++) drv_audio[k] = W'($urandom);
    tick();
    rearm_ch = 1;
    repeat (60) tick();
    check("setwins_grants", ghist.size(), 4);
    check("setwins_order2", (ghist.size() > 2) ? ghist[2] : -1, 2);
    check("setwins_order3", (ghist.size() > 3) ? ghist[3] : -1, 1);
    check("setwins_overrun", overrun, 4'b0000);

    // Random traffic with occasional engine stalls and stray eng_done pulses
    do_reset();
    mode_lat  = 0;
    hold_rate = 12;
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++) begin
        drv_valid[k] = ($urandom_range(7) == 0);
        drv_audio[k] = W'($urandom);
      end
      drv_done = ($urandom_range(19) == 0);
      drv_res  = W'($urandom);
      tick();
    end
    hold_rate = 0;
    repeat (150) tick();
    check("random_drained", m_pend, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
